// File: rtl/lz77_param_codec.sv
`default_nettype none
// ============================================================================
//  Module   : lz77_param_codec
//  Purpose  : Buffered LZ77 encoder / decoder. Encode mode stores a string,
//             then emits (offset, length, next-char) triples found by a
//             brute-force window search. Decode mode expands triples back
//             into symbols, one symbol per output beat.
//  Revision : 1.0  initial release
// ============================================================================
module lz77_param_codec #(
  parameter int DATA_W     = 8,
  parameter int SEARCH_LEN = 9,
  parameter int LOOK_LEN   = 8,
  parameter int MAX_STR    = 32,
  parameter int OFS_W      = $clog2(SEARCH_LEN),
  parameter int LEN_W      = $clog2(LOOK_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [DATA_W-1:0] in_char,
  input  logic [OFS_W-1:0]  in_pos,
  input  logic [LEN_W-1:0]  in_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [OFS_W-1:0]  out_offset,
  output logic [LEN_W-1:0]  out_len,
  output logic [DATA_W-1:0] out_char,
  output logic              busy
);

  // Index width must hold the string length itself (0..MAX_STR).
  localparam int IDX_W = $clog2(MAX_STR + 1);
  localparam int AW    = (MAX_STR > 1) ? $clog2(MAX_STR) : 1;

  localparam logic [IDX_W-1:0] ONE_I  = IDX_W'(1);
  localparam logic [LEN_W-1:0] ONE_L  = LEN_W'(1);
  localparam logic [LEN_W-1:0] CAP_HI = LEN_W'(LOOK_LEN - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SEARCH   = 3'd2,
    EMIT     = 3'd3,
    DEC_IN   = 3'd4,
    DEC_COPY = 3'd5,
    DEC_OUT  = 3'd6
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] str_buf [MAX_STR];

  // Control / datapath registers
  logic              ready_en;     // low during reset and the cycle it releases
  logic [IDX_W-1:0]  str_len;      // symbols stored for the current encode string
  logic [IDX_W-1:0]  cur;          // encode cursor L
  logic [IDX_W-1:0]  cand;         // candidate start p
  logic [LEN_W-1:0]  k;            // symbols matched so far at cand
  logic [LEN_W-1:0]  best_len;
  logic [IDX_W-1:0]  best_p;
  logic [OFS_W-1:0]  enc_ofs;
  logic [LEN_W-1:0]  enc_len;
  logic [DATA_W-1:0] enc_char;
  logic              enc_last;
  logic [IDX_W-1:0]  wr_idx;       // decode write pointer
  logic [DATA_W-1:0] dec_char;
  logic [OFS_W-1:0]  dec_pos;
  logic [LEN_W-1:0]  dec_left;     // copy symbols still to emit
  logic              dec_last;

  // Combinational helpers
  logic              accept, xfer;
  logic [IDX_W-1:0]  rem_m1;
  logic [LEN_W-1:0]  cap;
  logic              srch_done, sym_eq, cont, take;
  logic [LEN_W-1:0]  k_next, mlen;
  logic [IDX_W-1:0]  cur_nx, win_start, src;
  logic [OFS_W-1:0]  ofs_calc;
  logic              src_bad, wr_full, load_full;
  logic              buf_we;
  logic [IDX_W-1:0]  buf_wa;
  logic [DATA_W-1:0] buf_wd;

  function automatic logic [AW-1:0] to_addr(input logic [IDX_W-1:0] i);
    return AW'(i);
  endfunction

  assign accept = in_valid && in_ready;
  assign xfer   = out_valid && out_ready;
  assign busy   = (state != IDLE);

  // Search datapath: match-length cap, one symbol comparison, candidate scoring
  always_comb begin
    rem_m1    = str_len - cur - ONE_I;
    cap       = (32'(rem_m1) < 32'(LOOK_LEN - 1)) ? LEN_W'(rem_m1) : CAP_HI;
    srch_done = (cap == '0) || (cand == cur);
    sym_eq    = (str_buf[to_addr(cand + IDX_W'(k))] == str_buf[to_addr(cur + IDX_W'(k))]);
    k_next    = k + ONE_L;
    cont      = sym_eq && (k_next < cap);
    mlen      = sym_eq ? k_next : k;
    take      = (mlen != '0) && (mlen >= best_len);
    ofs_calc  = (best_len == '0) ? '0 : OFS_W'(cur - best_p - ONE_I);
    cur_nx    = cur + IDX_W'(enc_len) + ONE_I;
    win_start = (32'(cur_nx) > 32'(SEARCH_LEN)) ? (cur_nx - IDX_W'(SEARCH_LEN)) : '0;
    src_bad   = (32'(dec_pos) + 32'd1) > 32'(wr_idx);
    src       = wr_idx - IDX_W'(dec_pos) - ONE_I;
    wr_full   = (32'(wr_idx) == 32'(MAX_STR - 1));
    load_full = (32'(str_len) == 32'(MAX_STR - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state, handshake outputs and buffer write port
  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_offset = '0;
    out_len    = '0;
    out_char   = '0;
    buf_we     = 1'b0;
    buf_wa     = '0;
    buf_wd     = in_char;
    case (state)
      IDLE: begin
        in_ready = ready_en;
        if (accept) begin
          if (mode) begin
            state_nx = DEC_COPY;
          end else begin
            buf_we   = 1'b1;
            state_nx = (in_last || MAX_STR == 1) ? SEARCH : LOAD;
          end
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (accept) begin
          buf_we = 1'b1;
          buf_wa = str_len;
          if (in_last || load_full) state_nx = SEARCH;
        end
      end
      SEARCH: begin
        if (srch_done) state_nx = EMIT;
      end
      EMIT: begin
        out_valid  = 1'b1;
        out_last   = enc_last;
        out_offset = enc_ofs;
        out_len    = enc_len;
        out_char   = enc_char;
        if (out_ready) state_nx = enc_last ? IDLE : SEARCH;
      end
      DEC_IN: begin
        in_ready = 1'b1;
        if (accept) state_nx = DEC_COPY;
      end
      DEC_COPY: begin
        if (dec_left == '0) begin
          state_nx = DEC_OUT;
        end else if (src_bad) begin
          // Reference before the string start: close the string on this beat.
          out_valid = 1'b1;
          out_last  = 1'b1;
          out_char  = dec_char;
          if (out_ready) state_nx = IDLE;
        end else begin
          out_valid = 1'b1;
          out_last  = wr_full;
          out_char  = str_buf[to_addr(src)];
          if (out_ready) begin
            buf_we = 1'b1;
            buf_wa = wr_idx;
            buf_wd = str_buf[to_addr(src)];
            if (wr_full)               state_nx = IDLE;
            else if (dec_left == ONE_L) state_nx = DEC_OUT;
          end
        end
      end
      DEC_OUT: begin
        out_valid = 1'b1;
        out_last  = dec_last || wr_full;
        out_char  = dec_char;
        if (out_ready) begin
          buf_we   = 1'b1;
          buf_wa   = wr_idx;
          buf_wd   = dec_char;
          state_nx = (dec_last || wr_full) ? IDLE : DEC_IN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Symbol buffer; contents survive reset by design
  always_ff @(posedge clk) begin
    if (buf_we) str_buf[to_addr(buf_wa)] <= buf_wd;
  end

  // Datapath registers for loading, searching and decoding
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_en <= 1'b0;
      str_len  <= '0;
      cur      <= '0;
      cand     <= '0;
      k        <= '0;
      best_len <= '0;
      best_p   <= '0;
      wr_idx   <= '0;
      dec_left <= '0;
      dec_last <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            if (mode) begin
              dec_char <= in_char;
              dec_pos  <= in_pos;
              dec_left <= in_len;
              dec_last <= in_last;
              wr_idx   <= '0;
            end else begin
              str_len  <= ONE_I;
              cur      <= '0;
              cand     <= '0;
              k        <= '0;
              best_len <= '0;
              best_p   <= '0;
            end
          end
        end
        LOAD: begin
          if (accept) str_len <= str_len + ONE_I;
        end
        SEARCH: begin
          if (srch_done) begin
            enc_len  <= best_len;
            enc_ofs  <= ofs_calc;
            enc_char <= str_buf[to_addr(cur + IDX_W'(best_len))];
            enc_last <= ((cur + IDX_W'(best_len) + ONE_I) == str_len);
          end else if (cont) begin
            k <= k_next;
          end else begin
            k    <= '0;
            cand <= cand + ONE_I;
            if (take) begin
              best_len <= mlen;
              best_p   <= cand;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            cur      <= cur_nx;
            cand     <= win_start;
            k        <= '0;
            best_len <= '0;
            best_p   <= '0;
          end
        end
        DEC_IN: begin
          if (accept) begin
            dec_char <= in_char;
            dec_pos  <= in_pos;
            dec_left <= in_len;
            dec_last <= in_last;
          end
        end
        DEC_COPY: begin
          if (dec_left != '0 && !src_bad && out_ready) begin
            wr_idx   <= wr_idx + ONE_I;
            dec_left <= dec_left - ONE_L;
          end
        end
        DEC_OUT: begin
          if (out_ready) wr_idx <= wr_idx + ONE_I;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/lz77_param_codec.md
LZ77_PARAM_CODEC -- requirements
Module: lz77_param_codec

Interface
REQ-001 Parameter DATA_W, default 8, symbol width in bits.
REQ-002 Parameter SEARCH_LEN, default 9, search-window depth in symbols; OFS_W = clog2(SEARCH_LEN).
REQ-003 Parameter LOOK_LEN, default 8, look-ahead depth in symbols; LEN_W = clog2(LOOK_LEN).
REQ-004 Parameter MAX_STR, default 32, string-buffer depth in symbols.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 mode  input  1  0 = encode, 1 = decode; sampled only on the first accepted input of a string.
REQ-008 in_valid  input  1  input beat present.
REQ-009 in_ready  output  1  block accepts a beat when in_valid && in_ready.
REQ-010 in_last  input  1  final beat of the string (encode) or final triple (decode).
REQ-011 in_char  input  DATA_W  raw symbol (encode) or next-char field (decode).
REQ-012 in_pos  input  OFS_W  decode offset field.
REQ-013 in_len  input  LEN_W  decode match-length field.
REQ-014 out_valid  output  1  output beat present.
REQ-015 out_ready  input  1  downstream accepts; a transfer occurs on out_valid && out_ready.
REQ-016 out_last  output  1  final output beat of the string.
REQ-017 out_offset  output  OFS_W  encoded offset (distance-1); 0 in decode mode.
REQ-018 out_len  output  LEN_W  encoded match length; 0 in decode mode.
REQ-019 out_char  output  DATA_W  encoded next char, or decoded symbol.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, SEARCH, EMIT, DEC_IN, DEC_COPY, DEC_OUT.
REQ-022 IDLE: in_ready=1; on accept, mode=0 -> LOAD with symbol stored at index 0; mode=1 -> DEC_COPY with triple latched.
REQ-023 LOAD: one symbol stored per accepted beat; on in_last, or on the MAX_STR-th symbol (implicit last), go to SEARCH with in_ready=0.
REQ-024 SEARCH: cursor L starts at 0; candidates p in [max(0,L-SEARCH_LEN), L-1]; one symbol comparison per cycle.
REQ-025 A match may run into the look-ahead (overlap allowed).
REQ-026 Match length SHALL be capped at min(LOOK_LEN-1, remaining-1) so that a next char always exists.
REQ-027 Longest match wins; ties go to the largest p (smallest offset); out_offset = L-p-1.
REQ-028 No match (or L=0): triple (0,0,buf[L]).
REQ-029 EMIT: hold out_valid and all out_* stable until out_ready; on transfer L += len+1.
REQ-030 EMIT: if L = string length after the transfer, out_last=1 on that beat, then go to IDLE; otherwise go to SEARCH.
REQ-031 Per-triple latency SHALL be at most SEARCH_LEN*LOOK_LEN+2 cycles from SEARCH entry to out_valid.
REQ-032 DEC_COPY: copy in_len symbols from write_idx-in_pos-1 to write_idx, one per cycle, emitting each as an out beat; copy stalls while out_ready=0.
REQ-033 DEC_OUT: append and emit the latched char.
REQ-034 DEC_OUT: out_last=1 iff the triple had in_last; then go to IDLE if last, else DEC_IN.
REQ-035 DEC_IN: in_ready=1; accept the next triple, then go to DEC_COPY.
REQ-036 Decode source index below 0, or write_idx reaching MAX_STR, SHALL terminate the string: the current beat is forced out_last, then go to IDLE.
REQ-037 in_ready SHALL be 0 in SEARCH, EMIT, DEC_COPY and DEC_OUT.
REQ-038 in_valid during those states SHALL be ignored and held upstream.
REQ-039 Simultaneous out transfer and FSM advance SHALL occur in the same cycle with no bubble.

Reset
REQ-040 On reset=1 at a clock edge: state=IDLE, out_valid=0, out_last=0, out_offset=0, out_len=0, out_char=0, busy=0, in_ready=0.
REQ-041 in_ready SHALL become 1 on the first cycle after reset deasserts.
REQ-042 Reset mid-operation SHALL abandon the string with no further out beats; buffer contents need not be cleared.

Verification
REQ-043 Encode "AAAB" (last on B), out_ready=1 -> triples (0,0,A) then (0,2,B) with out_last.
REQ-044 Encode "ABC" -> (0,0,A), (0,0,B), (0,0,C) with out_last on C only.
REQ-045 Decode (0,0,X) then (0,3,Y) with in_last -> out_char X,X,X,X,Y; out_last on Y only.
REQ-046 Encode "ABAB" with out_ready low 5 cycles at each EMIT -> out_* stable while stalled; output (0,0,A), (0,0,B), (1,1,B) with out_last.
REQ-047 Reset asserted 2 cycles into SEARCH -> out_valid=0, busy=0 next cycle; a fresh encode of "Z" yields (0,0,Z) with out_last.
REQ-048 With MAX_STR=32, 33 symbols offered without in_last -> in_ready=0 after the 32nd; the final emitted triple carries out_last.
